led_frame_capture_buffer: RTL and testbench

- Parametrised, fully registered successor to the loop-indexed LED data demux.
- Captures DATA_W-bit beats addressed by loop_count into a NUM_CH-entry shadow bank and tracks which channels have been loaded.
- When every channel is loaded and CTS is granted, transfers the whole frame atomically to an active bank.
- The active bank drives the instruction-decoder data inputs, replacing the old latch-based per-channel assignment.

---
 rtl/led_frame_capture_buffer.sv | 111 +++++++++++
 tb/tb_led_frame_capture_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_capture_buffer.sv
// Double-banked LED frame capture: beats indexed by loop_count fill a shadow bank,
// and a complete frame is committed atomically to the active bank when CTS is granted.
module led_frame_capture_buffer #(
  parameter int DATA_W = 48,
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_resetb,
  input  logic                     init,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [IDX_W-1:0]         loop_count,
  input  logic [DATA_W-1:0]        DATA_i,
  input  logic                     CTS,
  input  logic                     error_flag,
  output logic [NUM_CH*DATA_W-1:0] DATA_output,
  output logic [NUM_CH-1:0]        loaded_mask,
  output logic                     frame_valid,
  output logic                     commit_pulse,
  output logic                     beat_err
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PEND
  } state_t;

  state_t                    state;
  logic [NUM_CH*DATA_W-1:0]  shadow;
  logic [NUM_CH-1:0]         beat_hit;
  logic                      in_range;
  logic                      dup_hit;
  logic                      completes;

  // One-hot decode of the beat target; all zeros means loop_count is out of range.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    beat_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      beat_hit[k] = (loop_count == IDX_W'(k));
    end
  end

  assign in_range   = |beat_hit;
  assign dup_hit    = |(beat_hit & loaded_mask);
  assign completes  = &(loaded_mask | beat_hit);
  assign data_ready = (state == FILL);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: both banks are reset because downstream decoders must see all-zero data
  // until the first commit; this costs a reset on every storage bit.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state        <= IDLE;
      shadow       <= '0;
      DATA_output  <= '0;
      loaded_mask  <= '0;
      frame_valid  <= 1'b0;
      commit_pulse <= 1'b0;
      beat_err     <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      beat_err     <= 1'b0;
      if (init) begin
        shadow      <= '0;
        DATA_output <= '0;
        loaded_mask <= '0;
        frame_valid <= 1'b0;
        state       <= FILL;
      end else begin
        case (state)
          IDLE: ;
          FILL: begin
            if (error_flag) begin
              loaded_mask <= '0;
            end else if (data_valid) begin
              if (in_range) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if (beat_hit[k]) shadow[k*DATA_W +: DATA_W] <= DATA_i;
                end
                loaded_mask <= loaded_mask | beat_hit;
                beat_err    <= dup_hit;
                if (completes) state <= PEND;
              end else begin
                beat_err <= 1'b1;
              end
            end
          end
          PEND: begin
            // Beats are not accepted here, so they neither load nor flag errors.
            if (error_flag) begin
              loaded_mask <= '0;
              state       <= FILL;
            end else if (CTS) begin
              DATA_output  <= shadow;
              loaded_mask  <= '0;
              frame_valid  <= 1'b1;
              commit_pulse <= 1'b1;
              state        <= FILL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_frame_capture_buffer.sv
// Directed bench for led_frame_capture_buffer: a 4-channel instance for the frame
// flow and a 3-channel instance for the out-of-range index case.
module tb_led_frame_capture_buffer;

  localparam int DW = 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel instance
  logic            a_init, a_valid, a_cts, a_err_flag;
  logic [1:0]      a_lc;
  logic [DW-1:0]   a_data;
  logic            a_ready, a_fvalid, a_commit, a_berr;
  logic [4*DW-1:0] a_out;
  logic [3:0]      a_mask;

  led_frame_capture_buffer #(.DATA_W(DW), .NUM_CH(4), .IDX_W(2)) dut_a (
    .sys_clk(clk), .sys_resetb(rst_n), .init(a_init), .data_valid(a_valid),
    .data_ready(a_ready), .loop_count(a_lc), .DATA_i(a_data), .CTS(a_cts),
    .error_flag(a_err_flag), .DATA_output(a_out), .loaded_mask(a_mask),
    .frame_valid(a_fvalid), .commit_pulse(a_commit), .beat_err(a_berr)
  );

  // 3-channel instance
  logic            b_init, b_valid, b_cts, b_err_flag;
  logic [1:0]      b_lc;
  logic [DW-1:0]   b_data;
  logic            b_ready, b_fvalid, b_commit, b_berr;
  logic [3*DW-1:0] b_out;
  logic [2:0]      b_mask;

  led_frame_capture_buffer #(.DATA_W(DW), .NUM_CH(3), .IDX_W(2)) dut_b (
    .sys_clk(clk), .sys_resetb(rst_n), .init(b_init), .data_valid(b_valid),
    .data_ready(b_ready), .loop_count(b_lc), .DATA_i(b_data), .CTS(b_cts),
    .error_flag(b_err_flag), .DATA_output(b_out), .loaded_mask(b_mask),
    .frame_valid(b_fvalid), .commit_pulse(b_commit), .beat_err(b_berr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [4*DW-1:0] got, input logic [4*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [1:0] idx, input logic [DW-1:0] d);
    a_valid = 1'b1; a_lc = idx; a_data = d;
    tick;
    a_valid = 1'b0;
  endtask

  task automatic b_beat(input logic [1:0] idx, input logic [DW-1:0] d);
    b_valid = 1'b1; b_lc = idx; b_data = d;
    tick;
    b_valid = 1'b0;
  endtask

  function automatic logic [4*DW-1:0] frame4(input logic [DW-1:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  logic [4*DW-1:0] frame_a, frame_b;

  initial begin
    rst_n = 1'b0;
    {a_init, a_valid, a_cts, a_err_flag, a_lc, a_data} = '0;
    {b_init, b_valid, b_cts, b_err_flag, b_lc, b_data} = '0;
    #1;
    check("rst_ready",  a_ready,  0);
    check("rst_mask",   a_mask,   0);
    check("rst_fvalid", a_fvalid, 0);
    check("rst_out",    a_out,    0);
    check("rst_commit", a_commit, 0);
    check("rst_berr",   a_berr,   0);
    #11 rst_n = 1'b1;
    tick;

    // Beat in IDLE is ignored
    a_beat(2'd0, 48'h55);
    check("idle_mask", a_mask, 0);
    check("idle_ready", a_ready, 0);

    a_init = 1'b1; tick; a_init = 1'b0;
    check("init_ready", a_ready, 1);

    // First frame, CTS low while filling
    for (int i = 0; i < 4; i++) a_beat(2'(i), DW'(48'hA0 + i));
    check("f1_mask",  a_mask,  4'hF);
    check("f1_ready", a_ready, 0);
    check("f1_out",   a_out,   0);
    a_beat(2'd0, 48'h99);  // ignored in PEND
    check("pend_beat_berr", a_berr, 0);
    check("pend_beat_mask", a_mask, 4'hF);
    a_cts = 1'b1; tick; a_cts = 1'b0;
    frame_a = frame4(48'hA3, 48'hA2, 48'hA1, 48'hA0);
    check("f1_commit_out", a_out,    frame_a);
    check("f1_commit",     a_commit, 1);
    check("f1_fvalid",     a_fvalid, 1);
    check("f1_mask_clr",   a_mask,   0);
    check("f1_ready_back", a_ready,  1);
    tick;
    check("f1_commit_1cyc", a_commit, 0);

    // Duplicate on ch2, last beat coincides with CTS
    a_beat(2'd2, 48'h111);
    check("dup_first_berr", a_berr, 0);
    a_beat(2'd2, 48'h222);
    check("dup_berr", a_berr, 1);
    check("dup_mask", a_mask, 4'h4);
    a_beat(2'd0, 48'hB0);
    check("dup_berr_clr", a_berr, 0);
    a_beat(2'd1, 48'hB1);
    a_cts = 1'b1;
    a_beat(2'd3, 48'hB3);
    check("simul_no_commit", a_commit, 0);
    check("simul_pend",      a_ready,  0);
    check("simul_out_old",   a_out,    frame_a);
    tick; a_cts = 1'b0;
    frame_b = frame4(48'hB3, 48'h222, 48'hB1, 48'hB0);
    check("f2_commit",     a_commit, 1);
    check("f2_out",        a_out,    frame_b);

    // error_flag in FILL with a same-cycle beat
    a_beat(2'd0, 48'hC0);
    a_beat(2'd1, 48'hC1);
    check("err_pre_mask", a_mask, 4'h3);
    a_err_flag = 1'b1;
    a_beat(2'd2, 48'hC2);
    a_err_flag = 1'b0;
    check("err_fill_mask",  a_mask,  0);
    check("err_fill_berr",  a_berr,  0);
    check("err_fill_out",   a_out,   frame_b);
    check("err_fill_ready", a_ready, 1);

    // error_flag in PEND
    for (int i = 0; i < 4; i++) a_beat(2'(i), DW'(48'hD0 + i));
    check("errp_pend", a_ready, 0);
    a_err_flag = 1'b1; a_cts = 1'b1; tick; a_err_flag = 1'b0; a_cts = 1'b0;
    check("errp_mask",   a_mask,   0);
    check("errp_ready",  a_ready,  1);
    check("errp_commit", a_commit, 0);
    check("errp_out",    a_out,    frame_b);

    // init together with CTS in PEND
    for (int i = 0; i < 4; i++) a_beat(2'(i), DW'(48'hE0 + i));
    check("initc_pend_mask", a_mask, 4'hF);
    a_init = 1'b1; a_cts = 1'b1; tick; a_init = 1'b0; a_cts = 1'b0;
    check("initc_commit", a_commit, 0);
    check("initc_out",    a_out,    0);
    check("initc_fvalid", a_fvalid, 0);
    check("initc_ready",  a_ready,  1);
    check("initc_mask",   a_mask,   0);

    // Commit a frame, reach PEND again, then asynchronous reset
    for (int i = 0; i < 4; i++) a_beat(2'(i), DW'(48'hF0 + i));
    a_cts = 1'b1; tick; a_cts = 1'b0;
    check("pre_rst_fvalid", a_fvalid, 1);
    for (int i = 0; i < 4; i++) a_beat(2'(i), DW'(48'h70 + i));
    check("pre_rst_pend", a_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out",    a_out,    0);
    check("arst_fvalid", a_fvalid, 0);
    check("arst_mask",   a_mask,   0);
    check("arst_ready",  a_ready,  0);
    tick;
    rst_n = 1'b1;
    a_beat(2'd0, 48'h33);
    check("post_rst_mask",  a_mask,  0);
    check("post_rst_ready", a_ready, 0);
    check("post_rst_berr",  a_berr,  0);
    a_init = 1'b1; tick; a_init = 1'b0;
    a_beat(2'd1, 48'h44);
    check("post_init_mask", a_mask, 4'h2);

    // 3-channel instance: out-of-range index
    b_init = 1'b1; tick; b_init = 1'b0;
    b_beat(2'd0, 48'h10);
    check("b_mask0", b_mask, 3'h1);
    b_beat(2'd3, 48'h13);
    check("b_oor_berr",  b_berr,  1);
    check("b_oor_mask",  b_mask,  3'h1);
    check("b_oor_ready", b_ready, 1);
    b_beat(2'd1, 48'h11);
    check("b_berr_clr", b_berr, 0);
    b_beat(2'd2, 48'h12);
    check("b_full_mask",  b_mask,  3'h7);
    check("b_full_ready", b_ready, 0);
    b_cts = 1'b1; tick; b_cts = 1'b0;
    check("b_commit_out", {48'h0, b_out}, {48'h0, 48'h12, 48'h11, 48'h10});
    check("b_commit",     b_commit, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
